// File: rtl/mcu_fpga_io_bridge.sv
// MCU 8-bit parallel bus slave exposing synchronized pin levels, direction bits
// and output latches of the FPGA general-purpose pins as byte-addressed registers.
module mcu_fpga_io_bridge #(
    parameter int PINS_CONT = 132
) (
    input  logic                 CLK50,
    input  logic                 rst_n,
    inout  wire  [7:0]           data,
    input  logic [7:0]           address,
    input  logic                 mcu_mstr,
    input  logic                 write_enable,
    output logic                 fpga_ready,
    inout  wire  [PINS_CONT-1:0] io_pins
);
    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t               state, state_nxt;
    logic                 access;
    logic                 mstr_sync_p0, mstr_sync_p1, mstr_sync_p2;
    logic                 mstr_s;
    logic [PINS_CONT-1:0] pin_sync_p0, pin_sync_p1;
    logic [PINS_CONT-1:0] dir_reg, out_reg;
    logic [PINS_CONT-1:0] wr_mask, wr_val;
    logic [7:0]           rd_data, rd_byte;
    logic [2:0]           bank;
    logic [4:0]           offset;

    assign bank   = address[7:5];
    assign offset = address[4:0];
    assign mstr_s = mstr_sync_p1;

    // Stage p0/p1: two-flop synchronizers; p2 is the delayed copy for edge detection
    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            mstr_sync_p0 <= 1'b1;
            mstr_sync_p1 <= 1'b1;
            mstr_sync_p2 <= 1'b1;
            pin_sync_p0  <= '0;
            pin_sync_p1  <= '0;
        end else begin
            mstr_sync_p0 <= mcu_mstr;
            mstr_sync_p1 <= mstr_sync_p0;
            mstr_sync_p2 <= mstr_sync_p1;
            pin_sync_p0  <= io_pins;
            pin_sync_p1  <= pin_sync_p0;
        end
    end

    // Byte lane select; offsets past the last bank byte match no pin and read as zero
    always_comb begin
        wr_mask = '0;
        wr_val  = '0;
        rd_byte = 8'h00;
        for (int i = 0; i < PINS_CONT; i++) begin
            if (offset == 5'(i / 8)) begin
                wr_mask[i] = 1'b1;
                wr_val[i]  = data[i % 8];
                case (bank)
                    3'd0:    rd_byte[i % 8] = pin_sync_p1[i];
                    3'd1:    rd_byte[i % 8] = dir_reg[i];
                    3'd2:    rd_byte[i % 8] = out_reg[i];
                    default: rd_byte[i % 8] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (mstr_s && !mstr_sync_p2) begin
                    access    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!mstr_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fpga_ready = (state == ACK);

    // Register bank update: one access per synchronized request edge
    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            dir_reg <= '0;
            out_reg <= '0;
            rd_data <= 8'h00;
        end else if (access) begin
            if (write_enable) begin
                if (bank == 3'd1) dir_reg <= (dir_reg & ~wr_mask) | (wr_val & wr_mask);
                if (bank == 3'd2) out_reg <= (out_reg & ~wr_mask) | (wr_val & wr_mask);
            end else begin
                rd_data <= rd_byte;
            end
        end
    end

    assign data = (rst_n && mcu_mstr && !write_enable) ? rd_data : 8'bz;

    for (genvar i = 0; i < PINS_CONT; i++) begin : g_pin
        assign io_pins[i] = dir_reg[i] ? out_reg[i] : 1'bz;
    end
endmodule

// File: tb/tb_mcu_fpga_io_bridge.sv
// Bench for mcu_fpga_io_bridge: directed scenarios plus randomized bus traffic
// checked against a flat bit-vector model of the register banks and pins.
module tb_mcu_fpga_io_bridge;
    localparam int PINS = 132;
    localparam int NB   = 17;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      address = 8'h00;
    logic            mcu_mstr = 1'b0;
    logic            write_enable = 1'b0;
    logic            fpga_ready;
    wire  [7:0]      data;
    wire  [PINS-1:0] io_pins;
    logic [7:0]      tb_data = 8'h00;
    logic            tb_data_oe = 1'b0;
    logic [PINS-1:0] pin_val = '0;
    logic [PINS-1:0] pin_oe = '1;
    logic [135:0]    dir_v = '0;
    logic [135:0]    out_v = '0;
    int              n_checks = 0;
    int              n_pass = 0;

    always #10 clk = ~clk;

    assign data = tb_data_oe ? tb_data : 8'bz;
    for (genvar i = 0; i < PINS; i++) begin : g_drv
        assign io_pins[i] = pin_oe[i] ? pin_val[i] : 1'bz;
    end

    mcu_fpga_io_bridge #(.PINS_CONT(PINS)) dut (
        .CLK50(clk), .rst_n(rst_n), .data(data), .address(address),
        .mcu_mstr(mcu_mstr), .write_enable(write_enable),
        .fpga_ready(fpga_ready), .io_pins(io_pins)
    );

    function automatic logic [135:0] model_pins();
        return (dir_v & out_v) | (~dir_v & {4'h0, pin_val});
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [135:0] in_v;
        int off;
        off  = int'(a[4:0]);
        in_v = model_pins();
        if (off >= NB) return 8'h00;
        case (a[7:5])
            3'd0:    return in_v[off*8 +: 8];
            3'd1:    return dir_v[off*8 +: 8];
            3'd2:    return out_v[off*8 +: 8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        int off;
        off = int'(a[4:0]);
        if (off < NB) begin
            if (a[7:5] == 3'd1) dir_v[off*8 +: 8] = d;
            if (a[7:5] == 3'd2) out_v[off*8 +: 8] = d;
        end
        dir_v[135:PINS] = '0;
        out_v[135:PINS] = '0;
    endtask

    task automatic model_reset();
        dir_v  = '0;
        out_v  = '0;
        pin_oe = '1;
    endtask

    // One MCU transfer; lat/fall count rising edges from request change to ready change
    task automatic bus_xfer(input logic we, input logic [7:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output int lat, output int fall);
        @(negedge clk);
        address = a; write_enable = we; tb_data = wd; tb_data_oe = we; mcu_mstr = 1'b1;
        lat = 99; fall = 99; rd = 8'h00;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (fpga_ready) begin lat = c; break; end
        end
        rd = data;
        if (we) model_write(a, wd);
        pin_oe = ~dir_v[PINS-1:0];
        @(negedge clk);
        mcu_mstr = 1'b0; tb_data_oe = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (!fpga_ready) begin fall = c; break; end
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd; int lat, fall;
        logic [7:0] addrs [3];
        addrs = '{8'h20, 8'h40, 8'h00};
        rst_n = 1'b0; model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (fpga_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", fpga_ready); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        foreach (addrs[k]) begin
            bus_xfer(1'b0, addrs[k], 8'h00, rd, lat, fall);
            n_checks++;
            if (rd !== 8'h00) $display("FAIL reset_read a=%02h got=%02h exp=00", addrs[k], rd); else n_pass++;
            n_checks++;
            if (lat < 2 || lat > 3) $display("FAIL reset_lat a=%02h got=%0d exp=2..3", addrs[k], lat); else n_pass++;
        end
        n_checks++;
        if (io_pins !== model_pins()[PINS-1:0]) $display("FAIL reset_pins got=%h exp=%h", io_pins, model_pins()[PINS-1:0]);
        else n_pass++;
    endtask

    task automatic test_out_drive();
        logic [7:0] rd; int lat, fall, acks;
        pin_val = PINS'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        bus_xfer(1'b1, 8'h25, 8'hFF, rd, lat, fall);
        n_checks++;
        if (lat < 2 || lat > 3) $display("FAIL dir_wr_lat got=%0d exp=2..3", lat); else n_pass++;
        bus_xfer(1'b1, 8'h45, 8'hA5, rd, lat, fall);
        n_checks++;
        if (lat < 2 || lat > 3) $display("FAIL out_wr_lat got=%0d exp=2..3", lat); else n_pass++;
        n_checks++;
        if (fall != 3) $display("FAIL ready_fall got=%0d exp=3", fall); else n_pass++;
        n_checks++;
        if (io_pins[47:40] !== 8'hA5) $display("FAIL pins_47_40 got=%02h exp=a5", io_pins[47:40]); else n_pass++;
        n_checks++;
        if (io_pins !== model_pins()[PINS-1:0]) $display("FAIL pins_all got=%h exp=%h", io_pins, model_pins()[PINS-1:0]);
        else n_pass++;
        acks = 0;
        repeat (6) begin @(posedge clk); #1; if (fpga_ready) acks++; end
        n_checks++;
        if (acks != 0) $display("FAIL one_ack_per_pulse got=%0d extra exp=0", acks); else n_pass++;
    endtask

    task automatic test_in_sync();
        logic [7:0] rd; int lat, fall, c;
        pin_val[7:0] = 8'h3C;
        repeat (3) @(posedge clk);
        bus_xfer(1'b0, 8'h00, 8'h00, rd, lat, fall);
        n_checks++;
        if (rd !== 8'h3C) $display("FAIL in_read got=%02h exp=3c", rd); else n_pass++;
        @(negedge clk);
        address = 8'h00; write_enable = 1'b0; mcu_mstr = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk) pin_val[7:0] = 8'hC3;
        c = 0;
        while (!fpga_ready && c < 8) begin @(posedge clk); #1; c++; end
        n_checks++;
        if (!fpga_ready || data !== 8'h3C) $display("FAIL in_old_value got=%02h rdy=%b exp=3c rdy=1", data, fpga_ready);
        else n_pass++;
        @(negedge clk) mcu_mstr = 1'b0;
        repeat (4) @(posedge clk);
        bus_xfer(1'b0, 8'h00, 8'h00, rd, lat, fall);
        n_checks++;
        if (rd !== 8'hC3) $display("FAIL in_new_value got=%02h exp=c3", rd); else n_pass++;
    endtask

    task automatic test_top_byte();
        logic [7:0] rd; int lat, fall;
        bus_xfer(1'b1, 8'h30, 8'hFF, rd, lat, fall);
        bus_xfer(1'b1, 8'h50, 8'hFF, rd, lat, fall);
        bus_xfer(1'b0, 8'h30, 8'h00, rd, lat, fall);
        n_checks++;
        if (rd !== 8'h0F) $display("FAIL top_dir got=%02h exp=0f", rd); else n_pass++;
        bus_xfer(1'b0, 8'h50, 8'h00, rd, lat, fall);
        n_checks++;
        if (rd !== 8'h0F) $display("FAIL top_out got=%02h exp=0f", rd); else n_pass++;
        n_checks++;
        if (io_pins[131:128] !== 4'hF) $display("FAIL top_pins got=%h exp=f", io_pins[131:128]); else n_pass++;
    endtask

    task automatic test_ignored_writes();
        logic [7:0] rd; int lat, fall;
        bus_xfer(1'b1, 8'h05, 8'h55, rd, lat, fall);
        n_checks++;
        if (lat < 2 || lat > 3) $display("FAIL in_wr_lat got=%0d exp=2..3", lat); else n_pass++;
        bus_xfer(1'b1, 8'h7F, 8'hAA, rd, lat, fall);
        n_checks++;
        if (lat < 2 || lat > 3) $display("FAIL unmapped_wr_lat got=%0d exp=2..3", lat); else n_pass++;
        bus_xfer(1'b0, 8'h7F, 8'h00, rd, lat, fall);
        n_checks++;
        if (rd !== 8'h00) $display("FAIL unmapped_read got=%02h exp=00", rd); else n_pass++;
        bus_xfer(1'b0, 8'h05, 8'h00, rd, lat, fall);
        n_checks++;
        if (rd !== 8'hA5) $display("FAIL in_after_write got=%02h exp=a5", rd); else n_pass++;
        bus_xfer(1'b0, 8'h45, 8'h00, rd, lat, fall);
        n_checks++;
        if (rd !== 8'hA5) $display("FAIL out_kept got=%02h exp=a5", rd); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] rd, a, d, exp; logic we; int lat, fall;
        for (int t = 0; t < 40; t++) begin
            pin_val = PINS'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            repeat (3) @(posedge clk);
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
            else a = {3'($urandom_range(0, 2)), 5'($urandom_range(0, 16))};
            we  = 1'($urandom_range(0, 1));
            d   = 8'($urandom());
            exp = model_read(a);
            bus_xfer(we, a, d, rd, lat, fall);
            n_checks++;
            if (lat < 2 || lat > 3) $display("FAIL rand_lat t=%0d got=%0d exp=2..3", t, lat); else n_pass++;
            n_checks++;
            if (we) begin
                if (io_pins !== model_pins()[PINS-1:0])
                    $display("FAIL rand_pins t=%0d a=%02h got=%h exp=%h", t, a, io_pins, model_pins()[PINS-1:0]);
                else n_pass++;
            end else begin
                if (rd !== exp) $display("FAIL rand_read t=%0d a=%02h got=%02h exp=%02h", t, a, rd, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] rd; int lat, fall, acks;
        @(negedge clk);
        address = 8'h41; write_enable = 1'b1; tb_data = 8'h77; tb_data_oe = 1'b1; mcu_mstr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; model_reset();
        #1;
        n_checks++;
        if (fpga_ready !== 1'b0) $display("FAIL abort_ready got=%b exp=0", fpga_ready); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        acks = 0;
        repeat (8) begin @(posedge clk); #1; if (fpga_ready) acks++; end
        n_checks++;
        if (acks != 0) $display("FAIL abort_no_ack got=%0d exp=0", acks); else n_pass++;
        @(negedge clk);
        mcu_mstr = 1'b0; tb_data_oe = 1'b0;
        repeat (3) @(posedge clk);
        bus_xfer(1'b0, 8'h41, 8'h00, rd, lat, fall);
        n_checks++;
        if (rd !== 8'h00) $display("FAIL abort_no_write got=%02h exp=00", rd); else n_pass++;
        bus_xfer(1'b1, 8'h41, 8'h77, rd, lat, fall);
        n_checks++;
        if (lat < 2 || lat > 3) $display("FAIL abort_fresh_lat got=%0d exp=2..3", lat); else n_pass++;
        bus_xfer(1'b0, 8'h41, 8'h00, rd, lat, fall);
        n_checks++;
        if (rd !== 8'h77) $display("FAIL abort_fresh_write got=%02h exp=77", rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_out_drive();
        test_in_sync();
        test_top_byte();
        test_ignored_writes();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "timeout");
    end
endmodule
